// File: rtl/conversor_bcd_display.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding four 7-segment decoders.
// Define APAGA_ZEROS_EN to blank leading zero digits with COD_APAGADO.
module conversor_bcd_display #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          N_BITS      = 14,
    parameter logic [3:0]  COD_APAGADO = 4'hF
) (
    input  logic                         clock_fpga,
    input  logic                         reset_n,
    input  logic                         inicia,
    input  logic signed [DATA_WIDTH-1:0] valor,
    output logic                         ocupado,
    output logic                         pronto,
    output logic                         negativo,
    output logic                         estouro,
    output logic [3:0]                   dp1,
    output logic [3:0]                   dp2,
    output logic [3:0]                   dp3,
    output logic [3:0]                   dp4
);

    localparam int CNT_W = $clog2(N_BITS + 1);
    localparam logic [DATA_WIDTH-1:0] LIMITE = DATA_WIDTH'(9999);

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        CONCLUI
    } estado_t;

    estado_t estado, prox_estado;

    logic [15:0]          bcd;
    logic [N_BITS-1:0]    bin;
    logic [CNT_W-1:0]     contador;
    logic [DATA_WIDTH-1:0] magnitude;
    logic                 acima;
    logic [N_BITS+15:0]   desloc;
    logic [15:0]          saida;

    // Add 3 to every nibble >= 5 so the following shift carries correctly into the next decade.
    function automatic logic [15:0] ajusta(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Blank leading zeros from the thousands digit down; units digit always shown.
    function automatic logic [15:0] apaga(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[15:12] == 4'd0) begin
            r[15:12] = COD_APAGADO;
            if (d[11:8] == 4'd0) begin
                r[11:8] = COD_APAGADO;
                if (d[7:4] == 4'd0)
                    r[7:4] = COD_APAGADO;
            end
        end
        return r;
    endfunction

    // Unsigned negation also covers the most negative value: -2^31 becomes 2^31.
    assign magnitude = valor[DATA_WIDTH-1] ? $unsigned(-valor) : $unsigned(valor);
    assign acima     = magnitude > LIMITE;
    assign desloc    = {ajusta(bcd), bin} << 1;

`ifdef APAGA_ZEROS_EN
    assign saida = apaga(bcd);
`else
    assign saida = bcd;
`endif

    assign ocupado = (estado == CONVERTE);

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (inicia) prox_estado = CONVERTE;
            CONVERTE: if (contador == CNT_W'(N_BITS - 1)) prox_estado = CONCLUI;
            CONCLUI:  prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock_fpga or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            bcd      <= '0;
            bin      <= '0;
            contador <= '0;
            pronto   <= 1'b0;
            negativo <= 1'b0;
            estouro  <= 1'b0;
            dp1      <= 4'd0;
            dp2      <= 4'd0;
            dp3      <= 4'd0;
            dp4      <= 4'd0;
        end else begin
            estado <= prox_estado;
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicia) begin
                        negativo <= valor[DATA_WIDTH-1];
                        estouro  <= acima;
                        bin      <= acima ? N_BITS'(9999) : magnitude[N_BITS-1:0];
                        bcd      <= '0;
                        contador <= '0;
                    end
                end
                CONVERTE: begin
                    bcd      <= desloc[N_BITS+15:N_BITS];
                    bin      <= desloc[N_BITS-1:0];
                    contador <= contador + 1'b1;
                end
                CONCLUI: begin
                    dp4    <= saida[15:12];
                    dp3    <= saida[11:8];
                    dp2    <= saida[7:4];
                    dp1    <= saida[3:0];
                    pronto <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
